// File: rtl/vgademo_pkg.sv
// Shared constants and FSM encoding for the VGA demo's floor-plane reciprocal divider.
// Widths follow the renderer's fixed-point format: 2^16 numerator, 9-bit row index, 11-bit step.
package vgademo_pkg;

    localparam int PLANE_NUM_LOG2 = 16;
    localparam int PLANE_DEN_W    = 9;
    localparam int PLANE_RECIP_W  = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } plane_state_e;

endpackage

// File: rtl/plane_recip_div_if.sv
// Request/result bundle between the scanline timing generator (master) and the divider (slave).
interface plane_recip_div_if
    import vgademo_pkg::*;
#(
    parameter int DEN_W   = PLANE_DEN_W,
    parameter int RECIP_W = PLANE_RECIP_W
);

    logic               start;
    logic [DEN_W-1:0]   denom;
    logic [RECIP_W-1:0] recip;
    logic               busy;
    logic               done;

    modport master (
        output start,
        output denom,
        input  recip,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  denom,
        output recip,
        output busy,
        output done
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract d<<k from the remainder with a single adder.
// The adder's borrow doubles as the comparison, so no separate comparator is needed.
module div_step
#(
    parameter int NUM_LOG2 = 16,
    parameter int DEN_W    = 9,
    parameter int RECIP_W  = 11,
    parameter int K_W      = 4
) (
    input  logic [NUM_LOG2:0]  i_rem,
    input  logic [DEN_W-1:0]   i_d,
    input  logic [K_W-1:0]     i_k,
    output logic [NUM_LOG2:0]  o_rem_next,
    output logic               o_qbit
);

    localparam int CMP_W = NUM_LOG2 + RECIP_W + 1;

    logic [CMP_W-1:0] w_dk;
    logic [CMP_W:0]   w_diff;
    logic             w_unused_hi;

    assign w_dk   = CMP_W'(i_d) << i_k;
    assign w_diff = {1'b0, CMP_W'(i_rem)} - {1'b0, w_dk};

    // No borrow means rem >= d<<k; the accepted difference then fits back in the remainder width.
    assign o_qbit      = ~w_diff[CMP_W];
    assign o_rem_next  = o_qbit ? w_diff[NUM_LOG2:0] : i_rem;
    assign w_unused_hi = ^w_diff[CMP_W-1:NUM_LOG2+1];

endmodule

// File: rtl/plane_recip_div.sv
// Iterative reciprocal divider: recip = floor(2^NUM_LOG2 / denom), saturated to RECIP_W bits,
// one quotient bit per cycle with a fixed latency of RECIP_W+1 cycles from the start cycle.
module plane_recip_div
    import vgademo_pkg::*;
#(
    parameter int NUM_LOG2 = PLANE_NUM_LOG2,
    parameter int DEN_W    = PLANE_DEN_W,
    parameter int RECIP_W  = PLANE_RECIP_W
) (
    input  logic             clk48,
    input  logic             rst_n,
    plane_recip_div_if.slave bus
);

    localparam int                K_W      = $clog2(RECIP_W);
    localparam logic [K_W-1:0]    K_MSB    = K_W'(RECIP_W - 1);
    localparam logic [NUM_LOG2:0] REM_INIT = {1'b1, {NUM_LOG2{1'b0}}};
    localparam logic [NUM_LOG2:0] SAT_LIM  = REM_INIT >> RECIP_W;

    plane_state_e        r_state;
    logic [K_W-1:0]      r_k;
    logic [DEN_W-1:0]    r_d;
    logic [NUM_LOG2:0]   r_rem;
    logic [RECIP_W-1:0]  r_q;
    logic                r_sat;
    logic [RECIP_W-1:0]  r_recip;
    logic                r_busy;
    logic                r_done;

    logic [NUM_LOG2:0]   w_rem_next;
    logic                w_qbit;
    logic [RECIP_W-1:0]  w_q_next;
    logic                w_sat;

    div_step #(
        .NUM_LOG2 (NUM_LOG2),
        .DEN_W    (DEN_W),
        .RECIP_W  (RECIP_W),
        .K_W      (K_W)
    ) u_step (
        .i_rem      (r_rem),
        .i_d        (r_d),
        .i_k        (r_k),
        .o_rem_next (w_rem_next),
        .o_qbit     (w_qbit)
    );

    // Quotients of 2^RECIP_W or more (including d=0) cannot be represented and clip to all-ones.
    assign w_sat    = ((NUM_LOG2+1)'(bus.denom) <= SAT_LIM);
    assign w_q_next = r_q | (RECIP_W'(w_qbit) << r_k);

    // Control FSM plus datapath registers; a new start always wins and restarts from scratch.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_k     <= {K_W{1'b0}};
            r_d     <= {DEN_W{1'b0}};
            r_rem   <= {(NUM_LOG2+1){1'b0}};
            r_q     <= {RECIP_W{1'b0}};
            r_sat   <= 1'b0;
            r_recip <= {RECIP_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.start) begin
                r_state <= RUN;
                r_k     <= K_MSB;
                r_d     <= bus.denom;
                r_rem   <= REM_INIT;
                r_q     <= {RECIP_W{1'b0}};
                r_sat   <= w_sat;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_busy <= 1'b0;
                    end
                    RUN: begin
                        r_rem <= w_rem_next;
                        r_q   <= w_q_next;
                        if (r_k == {K_W{1'b0}}) begin
                            // Commit with the last bit folded in so recip and done appear together.
                            r_state <= FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_recip <= r_sat ? {RECIP_W{1'b1}} : w_q_next;
                        end else begin
                            r_k <= r_k - K_W'(1);
                        end
                    end
                    FIN: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.recip = r_recip;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_plane_recip_div.sv
// Directed bench for plane_recip_div: inputs change and outputs are sampled on the falling edge.
module tb_plane_recip_div;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    plane_recip_div_if u_if ();

    plane_recip_div u_dut (
        .clk48 (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    // Caller sits on a falling edge; returns edges-to-done (40 on timeout) and the result.
    task automatic do_div(input logic [8:0] d, output int lat, output logic [10:0] res);
        u_if.start = 1'b1;
        u_if.denom = d;
        lat = 0;
        do begin
            @(negedge clk);
            u_if.start = 1'b0;
            lat++;
        end while (u_if.done !== 1'b1 && lat < 40);
        res = u_if.recip;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if (u_if.recip !== 11'd0) begin n_fail++; $display("FAIL reset_recip: got %0d want 0", u_if.recip); end
        n_tests++;
        if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", u_if.busy); end
        n_tests++;
        if (u_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", u_if.done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (u_if.busy !== 1'b0 || u_if.done !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", u_if.busy, u_if.done);
        end
    endtask

    task automatic test_basic_timing();
        u_if.start = 1'b1;
        u_if.denom = 9'd34;
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            u_if.start = 1'b0;
            n_tests++;
            if (u_if.busy !== (n <= 11)) begin
                n_fail++; $display("FAIL basic_busy cycle S+%0d: got %b want %b", n, u_if.busy, (n <= 11));
            end
            n_tests++;
            if (u_if.done !== (n == 12)) begin
                n_fail++; $display("FAIL basic_done cycle S+%0d: got %b want %b", n, u_if.done, (n == 12));
            end
            if (n == 12) begin
                n_tests++;
                if (u_if.recip !== 11'd1927) begin
                    n_fail++; $display("FAIL basic_recip: got %0d want 1927", u_if.recip);
                end
            end
        end
    endtask

    task automatic test_values();
        logic [8:0]  dv [7] = '{9'd273, 9'd33, 9'd32, 9'd0, 9'd100, 9'd200, 9'd1};
        logic [10:0] ev [7] = '{11'd240, 11'd1985, 11'd2047, 11'd2047, 11'd655, 11'd327, 11'd2047};
        int          lat;
        logic [10:0] res;
        for (int i = 0; i < 7; i++) begin
            do_div(dv[i], lat, res);
            n_tests++;
            if (lat !== 12) begin n_fail++; $display("FAIL values_latency d=%0d: got %0d want 12", dv[i], lat); end
            n_tests++;
            if (res !== ev[i]) begin n_fail++; $display("FAIL values_recip d=%0d: got %0d want %0d", dv[i], res, ev[i]); end
        end
    endtask

    task automatic test_abort();
        int n_done   = 0;
        int done_at  = 0;
        int seen_655 = 0;
        logic [10:0] res = 11'd0;
        u_if.start = 1'b1;
        u_if.denom = 9'd100;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            u_if.start = (n == 5);
            u_if.denom = 9'd200;
            if (u_if.recip === 11'd655) seen_655++;
            if (u_if.done === 1'b1) begin n_done++; done_at = n; res = u_if.recip; end
        end
        n_tests++;
        if (n_done !== 1) begin n_fail++; $display("FAIL abort_done_count: got %0d want 1", n_done); end
        n_tests++;
        if (done_at !== 17) begin n_fail++; $display("FAIL abort_done_cycle: got S+%0d want S+17", done_at); end
        n_tests++;
        if (res !== 11'd327) begin n_fail++; $display("FAIL abort_recip: got %0d want 327", res); end
        n_tests++;
        if (seen_655 !== 0) begin n_fail++; $display("FAIL abort_leak: aborted 655 seen %0d cycles want 0", seen_655); end
    endtask

    task automatic test_start_in_fin();
        int n = 0;
        int m = 0;
        u_if.start = 1'b1;
        u_if.denom = 9'd100;
        do begin
            @(negedge clk);
            u_if.start = 1'b0;
            n++;
        end while (u_if.done !== 1'b1 && n < 40);
        n_tests++;
        if (n !== 12 || u_if.recip !== 11'd655) begin
            n_fail++; $display("FAIL fin_first: done at S+%0d recip=%0d want S+12 655", n, u_if.recip);
        end
        u_if.start = 1'b1;
        u_if.denom = 9'd273;
        do begin
            @(negedge clk);
            u_if.start = 1'b0;
            m++;
        end while (u_if.done !== 1'b1 && m < 40);
        n_tests++;
        if (m !== 12) begin n_fail++; $display("FAIL fin_second_latency: got %0d want 12", m); end
        n_tests++;
        if (u_if.recip !== 11'd240) begin n_fail++; $display("FAIL fin_second_recip: got %0d want 240", u_if.recip); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int          lat;
        logic [10:0] res;
        u_if.start = 1'b1;
        u_if.denom = 9'd100;
        repeat (5) begin
            @(negedge clk);
            u_if.start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (u_if.recip !== 11'd0 || u_if.busy !== 1'b0 || u_if.done !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: recip=%0d busy=%b done=%b want 0 0 0", u_if.recip, u_if.busy, u_if.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_div(9'd34, lat, res);
        n_tests++;
        if (lat !== 12 || res !== 11'd1927) begin
            n_fail++; $display("FAIL post_reset_div: lat=%0d recip=%0d want 12 1927", lat, res);
        end
    endtask

    task automatic test_sweep();
        int          lat;
        logic [10:0] res;
        int          exp_q;
        for (int i = 0; i < 512; i++) begin
            if (i == 0) exp_q = 2047;
            else        exp_q = 65536 / i;
            if (exp_q > 2047) exp_q = 2047;
            do_div(9'(i), lat, res);
            n_tests++;
            if (lat !== 12) begin n_fail++; $display("FAIL sweep_latency d=%0d: got %0d want 12", i, lat); end
            n_tests++;
            if (res !== 11'(exp_q)) begin n_fail++; $display("FAIL sweep_recip d=%0d: got %0d want %0d", i, res, exp_q); end
        end
    endtask

    task automatic test_linewise();
        logic [8:0]  dv [4] = '{9'd1, 9'd40, 9'd100, 9'd511};
        logic [10:0] ev [4] = '{11'd2047, 11'd1638, 11'd655, 11'd128};
        int          lat;
        logic [10:0] res;
        for (int i = 0; i < 4; i++) begin
            do_div(dv[i], lat, res);
            n_tests++;
            if (lat >= 16) begin n_fail++; $display("FAIL line_window line %0d: done after %0d cycles want <16", i, lat); end
            n_tests++;
            if (res !== ev[i]) begin n_fail++; $display("FAIL line_recip line %0d: got %0d want %0d", i, res, ev[i]); end
            repeat (1525 - lat - 1) @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        u_if.start = 1'b0;
        u_if.denom = 9'd0;
        test_reset();
        test_basic_timing();
        test_values();
        test_abort();
        test_start_in_fin();
        test_async_reset();
        test_sweep();
        test_linewise();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
